sc_cmp_loader: RTL

Operand sequencer and result collector that sits directly upstream of the CC_GREATERTHAN inequality comparator. It accepts operand A then operand B over one shared valid/ready data bus and drives them as stable buses into the comparator. It samples the comparator's 1-bit result once both operands are present, registers it, and keeps a saturating count of mismatches for the top level.

---
 rtl/sc_cmp_loader_pkg.sv | 17 +
 rtl/sc_sat_counter.sv | 31 +++
 rtl/sc_cmp_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/sc_cmp_loader_pkg.sv
// Shared state encoding and default widths for the comparator operand loader.
package sc_cmp_loader_pkg;

  localparam int DEF_DATAWIDTH  = 8;
  localparam int DEF_COUNTWIDTH = 8;

  localparam logic [1:0] STATE_LOADA   = 2'b00;
  localparam logic [1:0] STATE_LOADB   = 2'b01;
  localparam logic [1:0] STATE_COMPARE = 2'b10;

  typedef enum logic [1:0] {
    S_LOADA   = STATE_LOADA,
    S_LOADB   = STATE_LOADB,
    S_COMPARE = STATE_COMPARE
  } state_e;

endpackage

// File: rtl/sc_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, clr_i wins over inc_i.
// One-cycle update latency, no backpressure.
module sc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sc_cmp_loader.sv
// Loads operand A then B from one valid/ready bus, samples the comparator result two edges later.
// Latency: result/done one edge after B; ready drops for the single compare cycle of each pair.
module sc_cmp_loader
  import sc_cmp_loader_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = DEF_DATAWIDTH,
  parameter int NUMBER_COUNTWIDTH = DEF_COUNTWIDTH
) (
  input  logic                         SC_CMPLOADER_CLOCK_50,
  input  logic                         SC_CMPLOADER_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0]  SC_CMPLOADER_data_InBUS,
  input  logic                         SC_CMPLOADER_valid_In,
  output logic                         SC_CMPLOADER_ready_Out,
  input  logic                         SC_CMPLOADER_clear_In,
  output logic [NUMBER_DATAWIDTH-1:0]  SC_CMPLOADER_dataA_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0]  SC_CMPLOADER_dataB_OutBUS,
  input  logic                         SC_CMPLOADER_cmp_In,
  output logic                         SC_CMPLOADER_result_Out,
  output logic                         SC_CMPLOADER_done_Out,
  output logic [NUMBER_COUNTWIDTH-1:0] SC_CMPLOADER_mismatchCount_OutBUS
);

  state_e                      state_q, state_d;
  logic [NUMBER_DATAWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                        result_q, result_d;
  logic                        done_q, done_d;
  logic                        ready, xfer, load_a, load_b, sample;

  always_ff @(posedge SC_CMPLOADER_CLOCK_50 or negedge SC_CMPLOADER_RESET_InLow) begin
    if (!SC_CMPLOADER_RESET_InLow) state_q <= S_LOADA;
    else                           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOADA:   if (xfer) state_d = S_LOADB;
      S_LOADB:   if (xfer) state_d = S_COMPARE;
      S_COMPARE: state_d = S_LOADA;
      default:   state_d = S_LOADA;
    endcase
  end

  always_comb begin
    ready  = (state_q != S_COMPARE);
    xfer   = SC_CMPLOADER_valid_In && ready;
    load_a = xfer && (state_q == S_LOADA);
    load_b = xfer && (state_q == S_LOADB);
    sample = (state_q == S_COMPARE);
  end

  // Clear only touches the result path; a pair in flight still completes and pulses done.
  always_comb begin
    a_d      = load_a ? SC_CMPLOADER_data_InBUS : a_q;
    b_d      = load_b ? SC_CMPLOADER_data_InBUS : b_q;
    done_d   = sample;
    result_d = result_q;
    if (SC_CMPLOADER_clear_In) result_d = 1'b0;
    else if (sample)           result_d = SC_CMPLOADER_cmp_In;
  end

  always_ff @(posedge SC_CMPLOADER_CLOCK_50 or negedge SC_CMPLOADER_RESET_InLow) begin
    if (!SC_CMPLOADER_RESET_InLow) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  sc_sat_counter #(.WIDTH(NUMBER_COUNTWIDTH)) u_mismatch_cnt (
    .clk_i   (SC_CMPLOADER_CLOCK_50),
    .rst_n_i (SC_CMPLOADER_RESET_InLow),
    .clr_i   (SC_CMPLOADER_clear_In),
    .inc_i   (sample && SC_CMPLOADER_cmp_In),
    .cnt_o   (SC_CMPLOADER_mismatchCount_OutBUS)
  );

  assign SC_CMPLOADER_ready_Out    = ready;
  assign SC_CMPLOADER_dataA_OutBUS = a_q;
  assign SC_CMPLOADER_dataB_OutBUS = b_q;
  assign SC_CMPLOADER_result_Out   = result_q;
  assign SC_CMPLOADER_done_Out     = done_q;

endmodule
